// File: rtl/key_event_queue.sv
// Key event queue between the keyboard decoder and game logic.
// Four-phase ready/read_fin handshakes on both sides; flush, occupancy and drop stats.
module key_event_queue #(
  parameter int unsigned DATA_WIDTH     = 3,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned LOG2_DEPTH     = $clog2(DEPTH),
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_read_fin,
  output logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  input  logic                      out_read_fin,
  input  logic                      flush,
  output logic [LOG2_DEPTH:0]       count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam logic [LOG2_DEPTH:0] DepthCnt = (LOG2_DEPTH+1)'(DEPTH);

  typedef enum logic {UIdle, UAck} ustate_e;
  typedef enum logic [1:0] {DIdle, DOffer, DWaitLow} dstate_e;

  ustate_e u_state_q, u_state_d;
  dstate_e d_state_q, d_state_d;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]       count_q, count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;

  logic capture, load, pop, push, drop, full;

  // Upstream: one capture per handshake, acknowledged regardless of queue space.
  always_comb begin
    u_state_d = u_state_q;
    capture   = 1'b0;
    case (u_state_q)
      UIdle: begin
        if (in_ready) begin
          capture   = 1'b1;
          u_state_d = UAck;
        end
      end
      UAck: begin
        if (!in_ready) u_state_d = UIdle;
      end
      default: u_state_d = UIdle;
    endcase
  end

  // Downstream: out_data is latched on entry to DOffer so it stays stable while offered.
  always_comb begin
    d_state_d = d_state_q;
    load      = 1'b0;
    pop       = 1'b0;
    case (d_state_q)
      DIdle: begin
        if (!flush && (count_q != '0) && !out_read_fin) begin
          load      = 1'b1;
          d_state_d = DOffer;
        end
      end
      DOffer: begin
        if (flush) begin
          d_state_d = out_read_fin ? DWaitLow : DIdle;
        end else if (out_read_fin) begin
          pop       = 1'b1;
          d_state_d = DWaitLow;
        end
      end
      DWaitLow: begin
        if (!out_read_fin) d_state_d = DIdle;
      end
      default: d_state_d = DIdle;
    endcase
  end

  assign full = (count_q == DepthCnt);
  // A same-cycle pop frees the head slot, so a full queue still accepts the event.
  assign push = capture && !flush && (!full || pop);
  assign drop = capture && !flush && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    out_data_d = out_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (LOG2_DEPTH+1)'(1);
        2'b01:   count_d = count_q - (LOG2_DEPTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_WIDTH'(1);
    if (load) out_data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      u_state_q  <= UIdle;
      d_state_q  <= DIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      out_data_q <= '0;
    end else begin
      u_state_q  <= u_state_d;
      d_state_q  <= d_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_read_fin = (u_state_q == UAck);
  assign out_ready   = (d_state_q == DOffer);
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign drop_count  = drop_q;

endmodule
